// File: rtl/free_list_if.sv
// Rename/commit-side port bundle of the 2-wide physical register free list.
// master = rename/commit pipeline, slave = free list.
interface free_list_if #(
    parameter int PRF_NUM_WIDTH = 6
);
    logic                     recover;
    logic                     alloc_req_0;
    logic                     alloc_req_1;
    logic                     rename_fire;
    logic                     alloc_stall;
    logic [PRF_NUM_WIDTH-1:0] prf_rd_new_0;
    logic [PRF_NUM_WIDTH-1:0] prf_rd_new_1;
    logic                     commit_0_valid;
    logic                     commit_1_valid;
    logic                     commit_0_wr;
    logic                     commit_1_wr;
    logic [PRF_NUM_WIDTH-1:0] commit_0_prf_stale;
    logic [PRF_NUM_WIDTH-1:0] commit_1_prf_stale;
    logic [PRF_NUM_WIDTH-1:0] free_count;

    modport master (
        output recover, alloc_req_0, alloc_req_1, rename_fire,
        output commit_0_valid, commit_1_valid, commit_0_wr, commit_1_wr,
        output commit_0_prf_stale, commit_1_prf_stale,
        input  alloc_stall, prf_rd_new_0, prf_rd_new_1, free_count
    );

    modport slave (
        input  recover, alloc_req_0, alloc_req_1, rename_fire,
        input  commit_0_valid, commit_1_valid, commit_0_wr, commit_1_wr,
        input  commit_0_prf_stale, commit_1_prf_stale,
        output alloc_stall, prf_rd_new_0, prf_rd_new_1, free_count
    );
endinterface

// File: rtl/free_list.sv
// Circular free list of PRF numbers: two allocations and two releases per cycle,
// with a committed head so a flush rolls back all speculative allocations at once.
module free_list #(
    parameter int PRF_NUM       = 64,
    parameter int PRF_NUM_WIDTH = 6,
    parameter int FL_DEPTH      = 32
) (
    input  logic       clk,
    input  logic       rst,
    free_list_if.slave fl
);
    localparam int IDX_W = $clog2(FL_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [PTR_W-1:0]         ptr_t;
    typedef logic [IDX_W-1:0]         idx_t;
    typedef logic [PRF_NUM_WIDTH-1:0] prf_t;

    prf_t entries [FL_DEPTH];
    ptr_t head;
    ptr_t cmt_head;
    ptr_t tail;

    ptr_t count;
    ptr_t n_req;
    ptr_t n_rel;
    logic rel_0;
    logic rel_1;
    logic stall;
    logic pop;
    idx_t rd_idx_0;
    idx_t rd_idx_1;
    idx_t wr_idx_0;
    idx_t wr_idx_1;

    // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
    always_comb begin
        rel_0    = fl.commit_0_valid && fl.commit_0_wr;
        rel_1    = fl.commit_1_valid && fl.commit_1_wr;
        n_req    = ptr_t'(fl.alloc_req_0) + ptr_t'(fl.alloc_req_1);
        n_rel    = ptr_t'(rel_0) + ptr_t'(rel_1);
        count    = tail - head;
        stall    = n_req > count;
        pop      = fl.rename_fire && !stall && !fl.recover;
        // Index arithmetic is IDX_W wide so slot-1 accesses wrap from FL_DEPTH-1 to 0.
        rd_idx_0 = head[IDX_W-1:0];
        rd_idx_1 = rd_idx_0 + idx_t'(1);
        wr_idx_0 = tail[IDX_W-1:0];
        wr_idx_1 = wr_idx_0 + idx_t'(rel_0);
    end

    assign fl.alloc_stall  = stall;
    assign fl.free_count   = PRF_NUM_WIDTH'(count);
    assign fl.prf_rd_new_0 = entries[rd_idx_0];
    assign fl.prf_rd_new_1 = fl.alloc_req_0 ? entries[rd_idx_1] : entries[rd_idx_0];

    // NOTE: the entry array is reset because its initial contents (PRF_NUM-FL_DEPTH+i)
    // are the free registers themselves, not don't-care storage.
    // NOTE: non-blocking assignments make head and cmt_head both see the pre-edge cmt_head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entries[i] <= prf_t'(PRF_NUM - FL_DEPTH + i);
            end
            head     <= '0;
            cmt_head <= '0;
            tail     <= ptr_t'(FL_DEPTH);
        end else begin
            if (rel_0) entries[wr_idx_0] <= fl.commit_0_prf_stale;
            if (rel_1) entries[wr_idx_1] <= fl.commit_1_prf_stale;
            tail     <= tail + n_rel;
            // Each committed write retires one allocation made earlier.
            cmt_head <= cmt_head + n_rel;
            if (fl.recover) begin
                head <= cmt_head + n_rel;
            end else if (pop) begin
                head <= head + n_req;
            end
        end
    end
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus randomized traffic
// checked against a queue-based model of free, in-flight and committed PRFs.
module tb_free_list;
    localparam int W = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;

    free_list_if #(.PRF_NUM_WIDTH(W)) fl ();

    free_list #(
        .PRF_NUM      (64),
        .PRF_NUM_WIDTH(W),
        .FL_DEPTH     (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fl (fl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: free_q in allocation order, inflight = speculatively allocated
    // (oldest first), arch_pool = PRFs currently mapped by committed state.
    int free_q[$];
    int inflight[$];
    int arch_pool[$];

    task automatic model_reset();
        free_q.delete();
        inflight.delete();
        arch_pool.delete();
        for (int i = 0; i < 32; i++) begin
            free_q.push_back(32 + i);
            arch_pool.push_back(i);
        end
    endtask

    task automatic model_step();
        int  n_req;
        int  n_rel;
        bit  rel0;
        bit  rel1;
        n_req = int'(fl.alloc_req_0) + int'(fl.alloc_req_1);
        rel0  = fl.commit_0_valid && fl.commit_0_wr;
        rel1  = fl.commit_1_valid && fl.commit_1_wr;
        n_rel = int'(rel0) + int'(rel1);
        if (free_q.size() + n_rel > 32) begin
            errors++;
            $display("FAIL overflow free=%0d released=%0d depth=32", free_q.size(), n_rel);
        end
        for (int k = 0; k < n_rel; k++) begin
            if (inflight.size() > 0) arch_pool.push_back(inflight.pop_front());
        end
        if (fl.recover) begin
            for (int i = inflight.size() - 1; i >= 0; i--) free_q.push_front(inflight[i]);
            inflight.delete();
        end else if (fl.rename_fire && n_req <= free_q.size()) begin
            for (int k = 0; k < n_req; k++) inflight.push_back(free_q.pop_front());
        end
        if (rel0) free_q.push_back(int'(fl.commit_0_prf_stale));
        if (rel1) free_q.push_back(int'(fl.commit_1_prf_stale));
    endtask

    task automatic set_in(input bit r0, input bit r1, input bit fire, input bit rec,
                          input bit c0v, input bit c0w, input int s0,
                          input bit c1v, input bit c1w, input int s1);
        fl.alloc_req_0        = r0;
        fl.alloc_req_1        = r1;
        fl.rename_fire        = fire;
        fl.recover            = rec;
        fl.commit_0_valid     = c0v;
        fl.commit_0_wr        = c0w;
        fl.commit_0_prf_stale = W'(s0);
        fl.commit_1_valid     = c1v;
        fl.commit_1_wr        = c1w;
        fl.commit_1_prf_stale = W'(s1);
    endtask

    task automatic req(input bit r0, input bit r1, input bit fire);
        set_in(r0, r1, fire, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    // Inputs change just after a falling edge; the model advances with the rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        req(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        req(1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (fl.alloc_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", fl.alloc_stall); end
        checks++; if (fl.free_count !== W'(32)) begin errors++; $display("FAIL reset_count got %0d exp 32", fl.free_count); end
        checks++; if (fl.prf_rd_new_0 !== W'(32)) begin errors++; $display("FAIL reset_new0 got %0d exp 32", fl.prf_rd_new_0); end
        checks++; if (fl.prf_rd_new_1 !== W'(32)) begin errors++; $display("FAIL reset_new1 got %0d exp 32", fl.prf_rd_new_1); end
    endtask

    task automatic test_dual_drain();
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            req(1'b1, 1'b1, 1'b1);
            #1;
            checks++; if (fl.prf_rd_new_0 !== W'(32 + 2 * k)) begin errors++; $display("FAIL drain_new0[%0d] got %0d exp %0d", k, fl.prf_rd_new_0, 32 + 2 * k); end
            checks++; if (fl.prf_rd_new_1 !== W'(33 + 2 * k)) begin errors++; $display("FAIL drain_new1[%0d] got %0d exp %0d", k, fl.prf_rd_new_1, 33 + 2 * k); end
            checks++; if (fl.alloc_stall !== 1'b0) begin errors++; $display("FAIL drain_stall[%0d] got %0b exp 0", k, fl.alloc_stall); end
            tick();
        end
        req(1'b1, 1'b1, 1'b1);
        #1;
        checks++; if (fl.free_count !== W'(0)) begin errors++; $display("FAIL empty_count got %0d exp 0", fl.free_count); end
        checks++; if (fl.alloc_stall !== 1'b1) begin errors++; $display("FAIL empty_stall_dual got %0b exp 1", fl.alloc_stall); end
        tick();
        req(1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (fl.alloc_stall !== 1'b1) begin errors++; $display("FAIL empty_stall_single got %0b exp 1", fl.alloc_stall); end
        checks++; if (fl.free_count !== W'(0)) begin errors++; $display("FAIL empty_no_pop got %0d exp 0", fl.free_count); end
        tick();
    endtask

    task automatic test_slot1_only();
        apply_reset();
        req(1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (fl.prf_rd_new_1 !== W'(32)) begin errors++; $display("FAIL slot1_new1 got %0d exp 32", fl.prf_rd_new_1); end
        tick();
        req(1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (fl.prf_rd_new_0 !== W'(33)) begin errors++; $display("FAIL slot1_next_new0 got %0d exp 33", fl.prf_rd_new_0); end
        checks++; if (fl.free_count !== W'(31)) begin errors++; $display("FAIL slot1_count got %0d exp 31", fl.free_count); end
    endtask

    task automatic test_partial_stall();
        apply_reset();
        for (int k = 0; k < 15; k++) begin
            req(1'b1, 1'b1, 1'b1);
            tick();
        end
        req(1'b1, 1'b0, 1'b1);
        tick();
        req(1'b1, 1'b1, 1'b1);
        #1;
        checks++; if (fl.free_count !== W'(1)) begin errors++; $display("FAIL one_left_count got %0d exp 1", fl.free_count); end
        checks++; if (fl.alloc_stall !== 1'b1) begin errors++; $display("FAIL one_left_stall got %0b exp 1", fl.alloc_stall); end
        tick();
        req(1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (fl.free_count !== W'(1)) begin errors++; $display("FAIL stall_no_pop got %0d exp 1", fl.free_count); end
        checks++; if (fl.alloc_stall !== 1'b0) begin errors++; $display("FAIL single_stall got %0b exp 0", fl.alloc_stall); end
        checks++; if (fl.prf_rd_new_1 !== W'(63)) begin errors++; $display("FAIL single_new1 got %0d exp 63", fl.prf_rd_new_1); end
        tick();
        req(1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (fl.free_count !== W'(0)) begin errors++; $display("FAIL single_count got %0d exp 0", fl.free_count); end
    endtask

    task automatic check_pairs(input string tag, input int exp_q[$]);
        for (int p = 0; p < exp_q.size() / 2; p++) begin
            req(1'b1, 1'b1, 1'b1);
            #1;
            checks++; if (fl.prf_rd_new_0 !== W'(exp_q[2 * p])) begin errors++; $display("FAIL %s_new0[%0d] got %0d exp %0d", tag, p, fl.prf_rd_new_0, exp_q[2 * p]); end
            checks++; if (fl.prf_rd_new_1 !== W'(exp_q[2 * p + 1])) begin errors++; $display("FAIL %s_new1[%0d] got %0d exp %0d", tag, p, fl.prf_rd_new_1, exp_q[2 * p + 1]); end
            tick();
        end
    endtask

    task automatic test_recover();
        int exp_q[$];
        apply_reset();
        repeat (3) begin
            req(1'b1, 1'b1, 1'b1);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b1, 7);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        tick();
        req(1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (fl.free_count !== W'(32)) begin errors++; $display("FAIL recover_count got %0d exp 32", fl.free_count); end
        checks++; if (fl.prf_rd_new_0 !== W'(34)) begin errors++; $display("FAIL recover_new0 got %0d exp 34", fl.prf_rd_new_0); end
        checks++; if (fl.prf_rd_new_1 !== W'(35)) begin errors++; $display("FAIL recover_new1 got %0d exp 35", fl.prf_rd_new_1); end
        for (int v = 34; v < 64; v++) exp_q.push_back(v);
        exp_q.push_back(3);
        exp_q.push_back(7);
        check_pairs("recover_seq", exp_q);
    endtask

    task automatic test_recover_same_cycle();
        int exp_q[$];
        apply_reset();
        repeat (2) begin
            req(1'b1, 1'b1, 1'b1);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b0, 0);
        tick();
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 9, 1'b1, 1'b1, 11);
        tick();
        req(1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (fl.free_count !== W'(32)) begin errors++; $display("FAIL samecyc_count got %0d exp 32", fl.free_count); end
        checks++; if (fl.prf_rd_new_0 !== W'(35)) begin errors++; $display("FAIL samecyc_new0 got %0d exp 35", fl.prf_rd_new_0); end
        for (int v = 35; v < 64; v++) exp_q.push_back(v);
        exp_q.push_back(5);
        exp_q.push_back(9);
        exp_q.push_back(11);
        check_pairs("samecyc_seq", exp_q);
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (3) begin
            req(1'b1, 1'b1, 1'b1);
            tick();
        end
        req(1'b1, 1'b1, 1'b1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (fl.free_count !== W'(32)) begin errors++; $display("FAIL async_count got %0d exp 32", fl.free_count); end
        checks++; if (fl.prf_rd_new_0 !== W'(32)) begin errors++; $display("FAIL async_new0 got %0d exp 32", fl.prf_rd_new_0); end
        checks++; if (fl.prf_rd_new_1 !== W'(33)) begin errors++; $display("FAIL async_new1 got %0d exp 33", fl.prf_rd_new_1); end
        req(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        bit r0, r1, fire, rec, c0v, c0w, c1v, c1w;
        int s0, s1, n_req, n_rel, sz, e1;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            r0   = 1'($urandom_range(0, 1));
            r1   = 1'($urandom_range(0, 1));
            fire = ($urandom_range(0, 3) != 0);
            rec  = ($urandom_range(0, 24) == 0);
            c0v  = ($urandom_range(0, 3) != 0);
            c0w  = ($urandom_range(0, 3) != 0);
            c1v  = ($urandom_range(0, 3) != 0);
            c1w  = ($urandom_range(0, 3) != 0);
            n_rel = int'(c0v && c0w) + int'(c1v && c1w);
            if (n_rel > inflight.size()) c1w = 1'b0;
            n_rel = int'(c0v && c0w) + int'(c1v && c1w);
            if (n_rel > inflight.size()) c0w = 1'b0;
            s0 = (c0v && c0w) ? arch_pool.pop_front() : int'($urandom_range(0, 63));
            s1 = (c1v && c1w) ? arch_pool.pop_front() : int'($urandom_range(0, 63));
            set_in(r0, r1, fire, rec, c0v, c0w, s0, c1v, c1w, s1);
            #1;
            n_req = int'(r0) + int'(r1);
            sz    = free_q.size();
            checks++; if (fl.free_count !== W'(sz)) begin errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", cyc, fl.free_count, sz); end
            checks++; if (fl.alloc_stall !== (n_req > sz)) begin errors++; $display("FAIL rand_stall[%0d] got %0b exp %0b", cyc, fl.alloc_stall, n_req > sz); end
            if (sz >= 1) begin
                checks++; if (fl.prf_rd_new_0 !== W'(free_q[0])) begin errors++; $display("FAIL rand_new0[%0d] got %0d exp %0d", cyc, fl.prf_rd_new_0, free_q[0]); end
            end
            if (r1 && sz >= n_req) begin
                e1 = r0 ? free_q[1] : free_q[0];
                checks++; if (fl.prf_rd_new_1 !== W'(e1)) begin errors++; $display("FAIL rand_new1[%0d] got %0d exp %0d", cyc, fl.prf_rd_new_1, e1); end
            end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dual_drain();
        test_slot1_only();
        test_partial_stall();
        test_recover();
        test_recover_same_cycle();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
